// File: rtl/halfband_decim_ts_param.sv
// halfband_decim_ts_param
// Parametrised half-band decimate-by-2 FIR, polyphase form, one time-shared
// multiplier. The centre tap is fixed at 0.5 and is applied as a shift. The
// odd-phase symmetric pairs are pre-added and then multiplied/accumulated one
// pair per clock. Coefficients can be loaded at run time, and the output is
// saturated to DATA_W.
// Build option: define HB_ROUND_EN to round half up before the COEF_W-bit
// truncation. When it is undefined the truncation is a plain floor.
module halfband_decim_ts_param #(
  parameter int DATA_W    = 18,
  parameter int COEF_W    = 18,
  parameter int NUM_PAIRS = 2,
  parameter int CA_W      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sam_clk_en,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     phase_sync,
  input  logic                     coef_we,
  input  logic        [CA_W-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     ovr_clr,
  output logic signed [DATA_W-1:0] y,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     sat,
  output logic                     ovr
);

  localparam int P      = NUM_PAIRS;
  localparam int KW     = (P > 1) ? $clog2(P) : 1;
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = DATA_W + COEF_W + 2 + $clog2(P);
  localparam int QW     = ACC_W + 1 - COEF_W;

  localparam logic signed [ACC_W:0] RND =
    {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-1){1'b0}}};
  localparam logic signed [QW-1:0] Y_MAX =
    {{(QW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [QW-1:0] Y_MIN =
    {{(QW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    OUT
  } state_t;

  state_t state, state_nxt;

  logic signed [COEF_W-1:0] coef [P];
  logic signed [DATA_W-1:0] e    [P+1];
  logic signed [DATA_W-1:0] o    [2*P];
  logic                     phase;
  logic                     p1_strobe;
  logic                     overrun;

  logic        [KW-1:0]     k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  centre;

  logic signed [DATA_W-1:0] tap_a, tap_b;
  logic signed [COEF_W-1:0] cf;
  logic signed [PRE_W-1:0]  pre;
  logic signed [PROD_W-1:0] prod;

  logic signed [ACC_W:0]    acc_r;
  logic signed [QW-1:0]     q;
  logic signed [DATA_W-1:0] y_next;
  logic                     clip;

  // phase_sync forces the current sample to phase 0, so only an unsynced
  // strobe that arrives in phase 1 counts as an odd sample.
  assign p1_strobe = sam_clk_en && !phase_sync && phase;
  assign overrun   = p1_strobe && (state != IDLE);
  assign busy      = (state != IDLE);

  // Centre term: e[P] * 0.5 in Q(COEF_W) scaling, i.e. e[P] <<< (COEF_W-1).
  assign centre = {{(ACC_W-DATA_W-COEF_W+1){e[P][DATA_W-1]}}, e[P],
                   {(COEF_W-1){1'b0}}};

  // Coefficient register file. Writes to addresses with no matching pair
  // index are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < P; i++) coef[i] <= '0;
    end else if (coef_we) begin
      for (int unsigned i = 0; i < P; i++) begin
        if (coef_addr == CA_W'(i)) coef[i] <= coef_data;
      end
    end
  end

  // Phase tracking and the even/odd polyphase delay lines.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= 1'b0;
      for (int unsigned i = 0; i <= P; i++)   e[i] <= '0;
      for (int unsigned i = 0; i < 2*P; i++) o[i] <= '0;
    end else if (sam_clk_en) begin
      phase <= phase_sync ? 1'b1 : ~phase;
      if (p1_strobe) begin
        o[0] <= x_in;
        for (int unsigned i = 1; i < 2*P; i++) o[i] <= o[i-1];
      end else begin
        e[0] <= x_in;
        for (int unsigned i = 1; i <= P; i++) e[i] <= e[i-1];
      end
    end else if (phase_sync) begin
      phase <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state. Any odd sample restarts the sequence, and that includes one
  // that arrives mid-sequence, which aborts the result in flight.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = IDLE;
      LOAD: state_nxt = MAC;
      MAC:  if (k == KW'(P-1)) state_nxt = OUT;
      OUT:  state_nxt = IDLE;
    endcase
    if (p1_strobe) state_nxt = LOAD;
  end

  // Select the current pair and its coefficient, then pre-add and multiply.
  always_comb begin
    tap_a = '0;
    tap_b = '0;
    cf    = '0;
    for (int unsigned i = 0; i < P; i++) begin
      if (k == KW'(i)) begin
        tap_a = o[P-1-i];
        tap_b = o[P+i];
        cf    = coef[i];
      end
    end
    pre  = PRE_W'(tap_a) + PRE_W'(tap_b);
    prod = PROD_W'(cf) * PROD_W'(pre);
  end

  // Optional rounding, truncation of COEF_W LSBs, then clip to DATA_W.
  always_comb begin
    acc_r = (ACC_W+1)'(acc);
`ifdef HB_ROUND_EN
    acc_r = acc_r + RND;
`endif
    q      = QW'(acc_r >>> COEF_W);
    clip   = 1'b0;
    y_next = q[DATA_W-1:0];
    if (q > Y_MAX) begin
      clip   = 1'b1;
      y_next = Y_MAX[DATA_W-1:0];
    end else if (q < Y_MIN) begin
      clip   = 1'b1;
      y_next = Y_MIN[DATA_W-1:0];
    end
  end

  // Accumulator, pair counter, output register and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc     <= '0;
      k       <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      sat     <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      sat     <= 1'b0;
      ovr     <= (ovr && !ovr_clr) || overrun;
      unique case (state)
        IDLE: ;
        LOAD: begin
          acc <= centre;
          k   <= '0;
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          k   <= k + KW'(1);
        end
        OUT: begin
          if (!p1_strobe) begin
            y       <= y_next;
            y_valid <= 1'b1;
            sat     <= clip;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_halfband_decim_ts_param.sv
// Scoreboard testbench for halfband_decim_ts_param (default parameters).
// Stimulus pushes hand-computed expected outputs. A negedge monitor pops one
// entry on each y_valid and compares the value, the sat flag and the arrival
// cycle.
module tb_halfband_decim_ts_param;

  localparam int DW  = 18;
  localparam int CW  = 18;
  localparam int P   = 2;
  localparam int AW  = 1;
  localparam int LAT = P + 2;

`ifdef HB_ROUND_EN
  localparam int IMP = 65536;
`else
  localparam int IMP = 65535;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sam_clk_en;
  logic signed [DW-1:0] x_in;
  logic                 phase_sync;
  logic                 coef_we;
  logic        [AW-1:0] coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 ovr_clr;
  logic signed [DW-1:0] y;
  logic                 y_valid;
  logic                 busy;
  logic                 sat;
  logic                 ovr;

  typedef struct {
    int y;
    bit sat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   ph     = 1'b0;

  halfband_decim_ts_param #(
    .DATA_W   (DW),
    .COEF_W   (CW),
    .NUM_PAIRS(P),
    .CA_W     (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sam_clk_en(sam_clk_en),
    .x_in      (x_in),
    .phase_sync(phase_sync),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .ovr_clr   (ovr_clr),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy),
    .sat       (sat),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every y_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && y_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_y_valid: got y=%0d at cycle %0d, expected no output", y, cyc);
      end else begin
        e = sb.pop_front();
        check("y", int'(y), e.y);
        check("sat", int'(sat), int'(e.sat));
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One input strobe. If it lands on phase 1 and chk is set, push the result
  // it should produce.
  task automatic smp(input int v, input bit sync, input bit clr, input bit chk,
                     input int ey, input bit es, input int gap);
    bit   p1;
    exp_t e;
    p1 = sync ? 1'b0 : ph;
    ph = sync ? 1'b1 : ~ph;
    if (p1 && chk) begin
      e.y   = ey;
      e.sat = es;
      e.cyc = cyc + 1 + LAT;
      sb.push_back(e);
    end
    sam_clk_en = 1'b1;
    x_in       = DW'(v);
    phase_sync = sync;
    ovr_clr    = clr;
    @(negedge clk);
    sam_clk_en = 1'b0;
    phase_sync = 1'b0;
    ovr_clr    = 1'b0;
    tick(gap - 1);
  endtask

  task automatic pair(input int v, input int ey, input bit es);
    smp(v, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4);
    smp(v, 1'b0, 1'b0, 1'b1, ey, es, 4);
  endtask

  task automatic wcoef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(d);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic clr_pulse();
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    sam_clk_en = 1'b0;
    x_in       = '0;
    phase_sync = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    ovr_clr    = 1'b0;
    tick(3);
    check("reset_y", int'(y), 0);
    check("reset_y_valid", int'(y_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_sat", int'(sat), 0);
    check("reset_ovr", int'(ovr), 0);
    reset = 1'b1;
    tick(1);

    wcoef(0, 74920);
    wcoef(1, -9220);

    // Impulse on one even sample: it reaches the centre tap two outputs later.
    smp(131071, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4);
    smp(0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 4);
    pair(0, 0, 1'b0);
    pair(0, IMP, 1'b0);
    pair(0, 0, 1'b0);

    // DC 65536 filling from empty lines.
    pair(65536, -2305, 1'b0);
    pair(65536, 16425, 1'b0);
    pair(65536, 67923, 1'b0);
    pair(65536, 65618, 1'b0);
    pair(65536, 65618, 1'b0);
    check("dc_ovr", int'(ovr), 0);

    // Step to negative full scale, which must saturate once settled.
    pair(-131072, 72533, 1'b0);
    pair(-131072, 16343, 1'b0);
    pair(-131072, -131072, 1'b1);
    pair(-131072, -131072, 1'b1);

    // Strobe every clock. Only the last trigger survives.
    for (int i = 0; i < 8; i++)
      smp(-131072, 1'b0, 1'b0, (i == 7), -131072, 1'b1, (i == 7) ? 8 : 1);
    check("ovr_after_burst", int'(ovr), 1);
    pair(-131072, -131072, 1'b1);
    pair(-131072, -131072, 1'b1);
    check("ovr_sticky", int'(ovr), 1);
    clr_pulse();
    check("ovr_cleared", int'(ovr), 0);

    // ovr_clr in the same clock as a new overrun leaves ovr set.
    smp(-131072, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1);
    smp(-131072, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1);
    smp(-131072, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1);
    smp(-131072, 1'b0, 1'b1, 1'b1, -131072, 1'b1, 8);
    check("ovr_clr_vs_overrun", int'(ovr), 1);

    // Reset while a MAC sequence is running.
    smp(-131072, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1);
    smp(-131072, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2);
    check("busy_mid_mac", int'(busy), 1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    ph    = 1'b0;
    check("rst_mid_y", int'(y), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ovr", int'(ovr), 0);
    tick(6);

    // Coefficients are cleared, so only the centre tap contributes.
    pair(65536, 0, 1'b0);
    pair(65536, 0, 1'b0);
    pair(65536, 32768, 1'b0);
    pair(65536, 32768, 1'b0);

    // Reload the coefficients, then resync the phase after an odd sample count.
    wcoef(0, 74920);
    wcoef(1, -9220);
    smp(65536, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4);
    smp(65536, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4);
    smp(65536, 1'b0, 1'b0, 1'b1, 65618, 1'b0, 4);
    pair(65536, 65618, 1'b0);
    pair(65536, 65618, 1'b0);
    // phase_sync without a strobe returns the phase to 0.
    smp(65536, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4);
    phase_sync = 1'b1;
    tick(1);
    phase_sync = 1'b0;
    ph         = 1'b0;
    tick(3);
    pair(65536, 65618, 1'b0);
    pair(65536, 65618, 1'b0);
    check("sync_ovr", int'(ovr), 0);

    tick(12);
    check("pending_outputs", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
